triangle_incenter_core: RTL and testbench

Computes the three side lengths and the incenter of a triangle whose three integer vertices arrive serially over a 3-beat in_valid burst. Results leave as a 3-beat out_valid burst in unsigned fixed point with 7 fractional bits. The block is the compute engine driven by the triangle-pattern bench. It uses iterative square-root and divide datapaths, so its latency is fixed.

---
 rtl/triangle_incenter_core.sv | 247 ++++++++++++++++++++++++
 tb/tb_triangle_incenter_core.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/triangle_incenter_core.sv
// Side lengths and incenter of an integer triangle received as a 3-beat burst.
// Sequential restoring square roots and divisions give a fixed 68-cycle latency.
module triangle_incenter_core #(
    parameter int COORD_W   = 5,
    parameter int FRAC_BITS = 7,
    parameter int OUT_W     = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [COORD_W-1:0] coord_x,
    input  logic [COORD_W-1:0] coord_y,
    output logic               out_valid,
    output logic [OUT_W-1:0]   out_length,
    output logic [OUT_W-1:0]   out_incenter
);
    localparam int D2_W   = 2*COORD_W + 1;
    localparam int RAD_W  = 2*OUT_W;
    localparam int RPAD   = RAD_W - D2_W - 2*FRAC_BITS;
    localparam int SREM_W = OUT_W + 4;
    localparam int P_W    = OUT_W + 2;
    localparam int DREM_W = P_W + 1;
    localparam int N_W    = OUT_W + COORD_W + 2;
    localparam int DVD_W  = N_W + FRAC_BITS;
    localparam logic [3:0] LAST_ITER = 4'(OUT_W - 1);

    typedef enum logic [2:0] {IDLE, LOAD, DIST, SQRT, SUM, DIV, OUT} state_t;

    state_t state;
    logic [3:0] iter;
    logic [1:0] pass;
    logic       ld_cnt;

    logic [COORD_W-1:0] x0, y0, x1, y1, x2, y2;
    logic [D2_W-1:0]    d2_a, d2_b, d2_c;
    logic [SREM_W-1:0]  sq_rem;
    logic [OUT_W-1:0]   sq_root;
    logic [OUT_W-1:0]   len_a, len_b, len_c;
    logic [P_W-1:0]     perim;
    logic [N_W-1:0]     nx, ny;
    logic [DREM_W-1:0]  dv_rem;
    logic [OUT_W-1:0]   dv_q;
    logic [OUT_W-1:0]   qx, qy;

    function automatic logic [D2_W-1:0] dist2(input logic [COORD_W-1:0] xa, input logic [COORD_W-1:0] ya,
                                              input logic [COORD_W-1:0] xb, input logic [COORD_W-1:0] yb);
        logic [COORD_W-1:0]   dx, dy;
        logic [2*COORD_W-1:0] sx, sy;
        dx = (xa > xb) ? xa - xb : xb - xa;
        dy = (ya > yb) ? ya - yb : yb - ya;
        sx = {{COORD_W{1'b0}}, dx} * {{COORD_W{1'b0}}, dx};
        sy = {{COORD_W{1'b0}}, dy} * {{COORD_W{1'b0}}, dy};
        return {1'b0, sx} + {1'b0, sy};
    endfunction

    // One restoring square-root digit: brings in two radicand bits, emits one root bit.
    function automatic logic [SREM_W+OUT_W-1:0] sqrt_step(input logic [SREM_W-1:0] rem,
                                                          input logic [OUT_W-1:0] root,
                                                          input logic [1:0] bits);
        logic [SREM_W-1:0] r, t;
        r = {rem[SREM_W-3:0], bits};
        t = {{(SREM_W-OUT_W-2){1'b0}}, root, 2'b01};
        if (r >= t) return {r - t, root[OUT_W-2:0], 1'b1};
        return {r, root[OUT_W-2:0], 1'b0};
    endfunction

    function automatic logic [DREM_W+OUT_W-1:0] div_step(input logic [DREM_W-1:0] rem,
                                                         input logic [OUT_W-1:0] q,
                                                         input logic bit_in,
                                                         input logic [P_W-1:0] divisor);
        logic [DREM_W-1:0] r, d;
        r = {rem[DREM_W-2:0], bit_in};
        d = {1'b0, divisor};
        if (r >= d) return {r - d, q[OUT_W-2:0], 1'b1};
        return {r, q[OUT_W-2:0], 1'b0};
    endfunction

    logic [D2_W-1:0]   d2_sel;
    logic [RAD_W-1:0]  rad;
    logic [4:0]        sh;
    logic [SREM_W-1:0] sq_rem_nx;
    logic [OUT_W-1:0]  sq_root_nx;
    logic [N_W-1:0]    num;
    logic [DVD_W-1:0]  dvd;
    logic [OUT_W-1:0]  dvd_lo;
    logic [DREM_W-1:0] dv_rem_in;
    logic [DREM_W-1:0] dv_rem_nx;
    logic [OUT_W-1:0]  dv_q_nx;
    logic [OUT_W-1:0]  q_fin;

    always_comb begin
        case (pass)
            2'd0:    d2_sel = d2_a;
            2'd1:    d2_sel = d2_b;
            default: d2_sel = d2_c;
        endcase
        rad = {{RPAD{1'b0}}, d2_sel, {(2*FRAC_BITS){1'b0}}};
        sh  = 5'(RAD_W - 2) - {iter, 1'b0};
        {sq_rem_nx, sq_root_nx} = sqrt_step((iter == '0) ? '0 : sq_rem,
                                            (iter == '0) ? '0 : sq_root, rad[sh +: 2]);

        num       = pass[0] ? ny : nx;
        dvd       = {num, {FRAC_BITS{1'b0}}};
        dvd_lo    = dvd[OUT_W-1:0];
        dv_rem_in = (iter == '0) ? DREM_W'(dvd[DVD_W-1:OUT_W]) : dv_rem;
        {dv_rem_nx, dv_q_nx} = div_step(dv_rem_in, (iter == '0) ? '0 : dv_q,
                                        dvd_lo[LAST_ITER - iter], perim);
        // Coincident vertices: perimeter is zero, the incenter is the vertex itself.
        if (perim == '0)
            q_fin = pass[0] ? OUT_W'({y0, {FRAC_BITS{1'b0}}}) : OUT_W'({x0, {FRAC_BITS{1'b0}}});
        else
            q_fin = dv_q_nx;
    end

    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (in_valid) begin
                x0 <= coord_x;
                y0 <= coord_y;
            end
            LOAD: if (in_valid) begin
                if (!ld_cnt) begin
                    x1 <= coord_x;
                    y1 <= coord_y;
                end else begin
                    x2 <= coord_x;
                    y2 <= coord_y;
                end
            end
            DIST: begin
                d2_a <= dist2(x1, y1, x2, y2);
                d2_b <= dist2(x2, y2, x0, y0);
                d2_c <= dist2(x0, y0, x1, y1);
            end
            SQRT: begin
                sq_rem  <= sq_rem_nx;
                sq_root <= sq_root_nx;
                if (iter == LAST_ITER) begin
                    case (pass)
                        2'd0:    len_a <= sq_root_nx;
                        2'd1:    len_b <= sq_root_nx;
                        default: len_c <= sq_root_nx;
                    endcase
                end
            end
            SUM: begin
                perim <= P_W'(len_a) + P_W'(len_b) + P_W'(len_c);
                nx    <= N_W'(len_a) * N_W'(x0) + N_W'(len_b) * N_W'(x1) + N_W'(len_c) * N_W'(x2);
                ny    <= N_W'(len_a) * N_W'(y0) + N_W'(len_b) * N_W'(y1) + N_W'(len_c) * N_W'(y2);
            end
            DIV: begin
                dv_rem <= dv_rem_nx;
                dv_q   <= dv_q_nx;
                if (iter == LAST_ITER) begin
                    if (pass[0]) qy <= q_fin;
                    else         qx <= q_fin;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            iter         <= '0;
            pass         <= '0;
            ld_cnt       <= 1'b0;
            out_valid    <= 1'b0;
            out_length   <= '0;
            out_incenter <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state  <= LOAD;
                    ld_cnt <= 1'b0;
                end
                LOAD: begin
                    if (!in_valid)  state  <= IDLE;
                    else if (ld_cnt) state <= DIST;
                    else            ld_cnt <= 1'b1;
                end
                DIST: begin
                    state <= SQRT;
                    iter  <= '0;
                    pass  <= '0;
                end
                SQRT: begin
                    if (iter == LAST_ITER) begin
                        iter <= '0;
                        if (pass == 2'd2) begin
                            pass  <= '0;
                            state <= SUM;
                        end else begin
                            pass <= pass + 2'd1;
                        end
                    end else begin
                        iter <= iter + 4'd1;
                    end
                end
                SUM: begin
                    state <= DIV;
                    iter  <= '0;
                    pass  <= '0;
                end
                DIV: begin
                    if (iter == LAST_ITER) begin
                        iter <= '0;
                        if (pass[0]) begin
                            pass  <= '0;
                            state <= OUT;
                        end else begin
                            pass <= 2'd1;
                        end
                    end else begin
                        iter <= iter + 4'd1;
                    end
                end
                OUT: begin
                    pass <= pass + 2'd1;
                    case (pass)
                        2'd0: begin
                            out_valid    <= 1'b1;
                            out_length   <= len_a;
                            out_incenter <= qx;
                        end
                        2'd1: begin
                            out_length   <= len_b;
                            out_incenter <= qy;
                        end
                        2'd2: begin
                            out_length   <= len_c;
                            out_incenter <= '0;
                        end
                        default: begin
                            out_valid    <= 1'b0;
                            out_length   <= '0;
                            out_incenter <= '0;
                            state        <= IDLE;
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_triangle_incenter_core.sv
// Directed and randomized checks of triangle_incenter_core lengths, incenter, latency and control.
module tb_triangle_incenter_core;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  coord_x, coord_y;
    logic        out_valid;
    logic [12:0] out_length, out_incenter;

    int n_vec = 0;
    int n_err = 0;
    int got_len[3];
    int got_inc[3];

    triangle_incenter_core dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .coord_x(coord_x), .coord_y(coord_y),
        .out_valid(out_valid), .out_length(out_length), .out_incenter(out_incenter)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input int obs, input int exp, input int tol);
        n_vec++;
        if (obs > exp + tol || obs < exp - tol) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int x, input int y);
        in_valid = 1'b1;
        coord_x  = 5'(x);
        coord_y  = 5'(y);
        tick();
    endtask

    // Sends a triangle, waits for the burst, records it and checks timing/valid shape.
    task automatic run_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input bit pulse);
        int n;
        send_beat(x0, y0);
        send_beat(x1, y1);
        send_beat(x2, y2);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
            if (pulse && n == 10) begin
                in_valid = 1'b1;
                coord_x  = 5'($urandom_range(31));
                coord_y  = 5'($urandom_range(31));
            end else if (pulse && n == 11) begin
                in_valid = 1'b0;
            end
        end
        check_vec("latency", n, 68, 0);
        for (int k = 0; k < 3; k++) begin
            check_vec("beat_valid", int'(out_valid), 1, 0);
            got_len[k] = int'(out_length);
            got_inc[k] = int'(out_incenter);
            tick();
        end
        check_vec("valid_end", int'(out_valid), 0, 0);
        check_vec("idle_length", int'(out_length), 0, 0);
        check_vec("idle_incenter", int'(out_incenter), 0, 0);
    endtask

    task automatic check_burst(input string tag, input int la, input int lb, input int lc,
                               input int ix, input int iy, input int tol);
        check_vec({tag, "_len_a"}, got_len[0], la, tol);
        check_vec({tag, "_len_b"}, got_len[1], lb, tol);
        check_vec({tag, "_len_c"}, got_len[2], lc, tol);
        check_vec({tag, "_ix"}, got_inc[0], ix, tol);
        check_vec({tag, "_iy"}, got_inc[1], iy, tol);
        check_vec({tag, "_inc2"}, got_inc[2], 0, 0);
    endtask

    initial begin
        int seen;
        int xs[3];
        int ys[3];
        real la, lb, lc, p, ix, iy;

        rst = 1'b1;
        in_valid = 1'b0;
        coord_x = '0;
        coord_y = '0;
        repeat (3) tick();
        check_vec("rst_valid", int'(out_valid), 0, 0);
        check_vec("rst_length", int'(out_length), 0, 0);
        check_vec("rst_incenter", int'(out_incenter), 0, 0);
        rst = 1'b0;
        tick();

        run_tri(0, 0, 3, 0, 0, 4, 1'b0);
        check_burst("t345", 640, 512, 384, 128, 128, 0);

        run_tri(0, 0, 31, 0, 0, 31, 1'b0);
        check_burst("tmax", 5611, 3968, 3968, 1162, 1162, 2);

        run_tri(7, 9, 7, 9, 7, 9, 1'b0);
        check_burst("tsame", 0, 0, 0, 896, 1152, 0);

        run_tri(0, 0, 2, 0, 4, 0, 1'b0);
        check_burst("tline", 256, 512, 256, 256, 0, 0);

        // Two-beat burst must be discarded.
        send_beat(5, 5);
        send_beat(6, 6);
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check_vec("abort_no_out", seen, 0, 0);
        run_tri(0, 0, 3, 0, 0, 4, 1'b0);
        check_burst("after_abort", 640, 512, 384, 128, 128, 0);

        // Reset in the middle of the square-root phase.
        send_beat(0, 0);
        send_beat(3, 0);
        send_beat(0, 4);
        in_valid = 1'b0;
        repeat (31) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_vec("rst_sqrt_valid", int'(out_valid), 0, 0);
        check_vec("rst_sqrt_length", int'(out_length), 0, 0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check_vec("rst_sqrt_no_out", seen, 0, 0);

        // Reset while a burst is on the outputs.
        send_beat(0, 0);
        send_beat(3, 0);
        send_beat(0, 4);
        in_valid = 1'b0;
        repeat (68) tick();
        check_vec("pre_rst_valid", int'(out_valid), 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_vec("rst_out_valid", int'(out_valid), 0, 0);
        check_vec("rst_out_length", int'(out_length), 0, 0);
        check_vec("rst_out_incenter", int'(out_incenter), 0, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check_vec("rst_out_no_more", seen, 0, 0);

        for (int t = 0; t < 600; t++) begin
            for (int v = 0; v < 3; v++) begin
                xs[v] = int'($urandom_range(31));
                ys[v] = int'($urandom_range(31));
            end
            run_tri(xs[0], ys[0], xs[1], ys[1], xs[2], ys[2], (t % 4) == 0);
            la = $sqrt(real'((xs[1]-xs[2])*(xs[1]-xs[2]) + (ys[1]-ys[2])*(ys[1]-ys[2])));
            lb = $sqrt(real'((xs[2]-xs[0])*(xs[2]-xs[0]) + (ys[2]-ys[0])*(ys[2]-ys[0])));
            lc = $sqrt(real'((xs[0]-xs[1])*(xs[0]-xs[1]) + (ys[0]-ys[1])*(ys[0]-ys[1])));
            p = la + lb + lc;
            if (p == 0.0) begin
                ix = real'(xs[0]);
                iy = real'(ys[0]);
            end else begin
                ix = (la*xs[0] + lb*xs[1] + lc*xs[2]) / p;
                iy = (la*ys[0] + lb*ys[1] + lc*ys[2]) / p;
            end
            check_burst("rand", $rtoi(la*128.0 + 0.5), $rtoi(lb*128.0 + 0.5), $rtoi(lc*128.0 + 0.5),
                        $rtoi(ix*128.0 + 0.5), $rtoi(iy*128.0 + 0.5), 12);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
